// File: rtl/iir_resp_buffer_pkg.sv
// Shared types and default widths for the IIR frequency-response capture buffer.
package iir_resp_buffer_pkg;

  localparam int DEF_CONFIG_SIZE = 16;
  localparam int DEF_XY_BITS     = 16;
  localparam int DEF_PHASE_BITS  = 16;
  localparam int DEF_DEPTH       = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_XY_BITS-1:0]    mag;
    logic [DEF_PHASE_BITS-1:0] phase;
  } entry_t;

endpackage

// File: rtl/iir_resp_buffer_mem.sv
// Simple dual-port entry store: one write port, one read port, registered read data (1 cycle).
// No backpressure; contents are never cleared.
module iir_resp_buf_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          i_wr_vld,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_dat,
  input  logic          i_rd_vld,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_dat
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_dat;

  always_ff @(posedge clk) begin
    if (i_wr_vld) r_mem[i_wr_addr] <= i_wr_dat;
    if (i_rd_vld) r_rd_dat <= r_mem[i_rd_addr];
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/iir_resp_buffer.sv
// Captures one evaluator response vector (mag/phase per bin) and serves reads with 1-cycle latency.
// No backpressure: overruns set ovf_err; optional notch tracking under IIR_RESP_MIN_TRACK_EN.
module iir_resp_buffer
  import iir_resp_buffer_pkg::*;
#(
  parameter int CONFIG_SIZE = DEF_CONFIG_SIZE,
  parameter int XY_BITS     = DEF_XY_BITS,
  parameter int PHASE_BITS  = DEF_PHASE_BITS,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CONFIG_SIZE-1:0] config_nfft,
  input  logic                   start,
  output logic                   eval_iir_freq_resp,
  input  logic [XY_BITS-1:0]     tf_val_magnitude,
  input  logic [PHASE_BITS-1:0]  tf_val_phase,
  input  logic                   tf_val_valid,
  input  logic                   freq_eval_done,
  output logic                   ready,
  input  logic                   rd_en,
  input  logic [CONFIG_SIZE-1:0] rd_idx,
  output logic                   rd_valid,
  output logic [XY_BITS-1:0]     rd_mag,
  output logic [PHASE_BITS-1:0]  rd_phase,
  output logic                   short_err,
  output logic                   ovf_err,
  output logic                   cfg_err,
  output logic [XY_BITS-1:0]     min_mag,
  output logic [CONFIG_SIZE-1:0] min_bin
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = XY_BITS + PHASE_BITS;
  localparam logic [CONFIG_SIZE-1:0] LP_DEPTH = CONFIG_SIZE'(DEPTH);

  state_t                 r_state;
  logic [CONFIG_SIZE-1:0] r_nfft;
  logic [CONFIG_SIZE-1:0] r_wr_ptr;
  logic                   r_eval;
  logic                   r_ready;
  logic                   r_short;
  logic                   r_ovf;
  logic                   r_cfg;
  logic                   r_rd_valid;
  logic                   r_rd_inrange;

  logic                   w_cfg_ok;
  logic                   w_start_ok;
  logic                   w_wr;
  logic                   w_ovf;
  logic                   w_rd;
  logic [CONFIG_SIZE-1:0] w_cnt_next;
  logic [DW-1:0]          w_rd_dat;

  assign w_cfg_ok   = (config_nfft != '0) && (config_nfft <= LP_DEPTH);
  assign w_start_ok = start && (r_state != CAPTURE) && w_cfg_ok;
  assign w_wr       = (r_state == CAPTURE) && tf_val_valid && (r_wr_ptr < r_nfft);
  assign w_ovf      = (r_state == CAPTURE) && tf_val_valid && (r_wr_ptr >= r_nfft);
  assign w_rd       = rd_en && (r_state == READY);
  // A write coinciding with done still counts toward the final length.
  assign w_cnt_next = r_wr_ptr + CONFIG_SIZE'(w_wr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_nfft       <= '0;
      r_wr_ptr     <= '0;
      r_eval       <= 1'b0;
      r_ready      <= 1'b0;
      r_short      <= 1'b0;
      r_ovf        <= 1'b0;
      r_cfg        <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_inrange <= 1'b0;
    end else begin
      r_rd_valid   <= w_rd;
      r_rd_inrange <= w_rd && (rd_idx < r_nfft);
      case (r_state)
        IDLE, READY: begin
          if (w_start_ok) begin
            r_state  <= CAPTURE;
            r_nfft   <= config_nfft;
            r_wr_ptr <= '0;
            r_eval   <= 1'b1;
            r_ready  <= 1'b0;
            r_short  <= 1'b0;
            r_ovf    <= 1'b0;
            r_cfg    <= 1'b0;
          end else if (start) begin
            r_cfg <= 1'b1;
          end
        end
        CAPTURE: begin
          if (w_wr)  r_wr_ptr <= w_cnt_next;
          if (w_ovf) r_ovf    <= 1'b1;
          if (freq_eval_done) begin
            r_state <= READY;
            r_eval  <= 1'b0;
            r_ready <= 1'b1;
            if (w_cnt_next != r_nfft) r_short <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  iir_resp_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_mem (
    .clk       (clk),
    .i_wr_vld  (w_wr),
    .i_wr_addr (AW'(r_wr_ptr)),
    .i_wr_dat  ({tf_val_magnitude, tf_val_phase}),
    .i_rd_vld  (w_rd),
    .i_rd_addr (AW'(rd_idx)),
    .o_rd_dat  (w_rd_dat)
  );

  assign eval_iir_freq_resp = r_eval;
  assign ready              = r_ready;
  assign short_err          = r_short;
  assign ovf_err            = r_ovf;
  assign cfg_err            = r_cfg;
  assign rd_valid           = r_rd_valid;
  assign rd_mag             = r_rd_inrange ? w_rd_dat[DW-1:PHASE_BITS] : '0;
  assign rd_phase           = r_rd_inrange ? w_rd_dat[PHASE_BITS-1:0]  : '0;

`ifdef IIR_RESP_MIN_TRACK_EN
  logic [XY_BITS-1:0]     r_min_mag;
  logic [CONFIG_SIZE-1:0] r_min_bin;

  // Strict less-than keeps the earliest bin when magnitudes tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_min_mag <= '1;
      r_min_bin <= '0;
    end else if (w_start_ok) begin
      r_min_mag <= '1;
      r_min_bin <= '0;
    end else if (w_wr && (tf_val_magnitude < r_min_mag)) begin
      r_min_mag <= tf_val_magnitude;
      r_min_bin <= r_wr_ptr;
    end
  end

  assign min_mag = r_min_mag;
  assign min_bin = r_min_bin;
`else
  assign min_mag = '0;
  assign min_bin = '0;
`endif

endmodule

// File: tb/tb_iir_resp_buffer.sv
// Directed bench for iir_resp_buffer: read responses go through a scoreboard queue,
// control/status flags are checked in line with the stimulus.
module tb_iir_resp_buffer;
  import iir_resp_buffer_pkg::*;

  localparam int CS    = 16;
  localparam int XB    = 16;
  localparam int PB    = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CS-1:0] config_nfft = '0;
  logic          start = 1'b0;
  logic          eval_iir_freq_resp;
  logic [XB-1:0] tf_val_magnitude = '0;
  logic [PB-1:0] tf_val_phase = '0;
  logic          tf_val_valid = 1'b0;
  logic          freq_eval_done = 1'b0;
  logic          ready;
  logic          rd_en = 1'b0;
  logic [CS-1:0] rd_idx = '0;
  logic          rd_valid;
  logic [XB-1:0] rd_mag;
  logic [PB-1:0] rd_phase;
  logic          short_err, ovf_err, cfg_err;
  logic [XB-1:0] min_mag;
  logic [CS-1:0] min_bin;

  iir_resp_buffer #(
    .CONFIG_SIZE (CS),
    .XY_BITS     (XB),
    .PHASE_BITS  (PB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .config_nfft        (config_nfft),
    .start              (start),
    .eval_iir_freq_resp (eval_iir_freq_resp),
    .tf_val_magnitude   (tf_val_magnitude),
    .tf_val_phase       (tf_val_phase),
    .tf_val_valid       (tf_val_valid),
    .freq_eval_done     (freq_eval_done),
    .ready              (ready),
    .rd_en              (rd_en),
    .rd_idx             (rd_idx),
    .rd_valid           (rd_valid),
    .rd_mag             (rd_mag),
    .rd_phase           (rd_phase),
    .short_err          (short_err),
    .ovf_err            (ovf_err),
    .cfg_err            (cfg_err),
    .min_mag            (min_mag),
    .min_bin            (min_bin)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  entry_t exp_q[$];
  entry_t mon_e;

`ifdef IIR_RESP_MIN_TRACK_EN
  localparam logic [XB-1:0] RST_MIN_MAG = '1;
  localparam logic [XB-1:0] EXP_MIN_MAG = 16'd20;
  localparam logic [CS-1:0] EXP_MIN_BIN = 16'd1;
`else
  localparam logic [XB-1:0] RST_MIN_MAG = '0;
  localparam logic [XB-1:0] EXP_MIN_MAG = '0;
  localparam logic [CS-1:0] EXP_MIN_BIN = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic entry_t mk(input logic [XB-1:0] m, input logic [PB-1:0] p);
    entry_t e;
    e.mag   = m;
    e.phase = p;
    return e;
  endfunction

  // Scoreboard monitor: every rd_valid cycle must match the oldest expected read.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got rd_valid=1 mag=%0d phase=0x%0h, expected no response at %0t", rd_mag, rd_phase, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_mag", 32'(rd_mag), 32'(mon_e.mag));
        chk("rd_phase", 32'(rd_phase), 32'(mon_e.phase));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CS-1:0] n);
    config_nfft = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_valid(input logic [XB-1:0] m, input logic [PB-1:0] p, input logic done);
    tf_val_valid = 1'b1;
    tf_val_magnitude = m;
    tf_val_phase = p;
    freq_eval_done = done;
    tick();
    tf_val_valid = 1'b0;
    freq_eval_done = 1'b0;
  endtask

  task automatic do_done();
    freq_eval_done = 1'b1;
    tick();
    freq_eval_done = 1'b0;
  endtask

  task automatic do_read(input logic [CS-1:0] idx, input entry_t e);
    rd_en = 1'b1;
    rd_idx = idx;
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic rdy, input logic sh, input logic ov, input logic cf);
    chk({tag, "_ready"}, 32'(ready), 32'(rdy));
    chk({tag, "_short"}, 32'(short_err), 32'(sh));
    chk({tag, "_ovf"}, 32'(ovf_err), 32'(ov));
    chk({tag, "_cfg"}, 32'(cfg_err), 32'(cf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_eval", 32'(eval_iir_freq_resp), 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_min_mag", 32'(min_mag), 32'(RST_MIN_MAG));
    chk("rst_min_bin", 32'(min_bin), 32'd0);
    rst_n = 1'b1;
    tick();

    // Read outside READY gets no response
    rd_en = 1'b1;
    rd_idx = 16'd0;
    tick();
    rd_en = 1'b0;
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);

    // Full capture, nfft=8, mag = 100-k
    do_start(16'd8);
    chk("a_eval_on", 32'(eval_iir_freq_resp), 32'd1);
    chk("a_ready_cap", 32'(ready), 32'd0);
    for (int k = 0; k < 8; k++) do_valid(XB'(100 - k), PB'(16'h1000 + k), 1'b0);
    do_done();
    chk("a_eval_off", 32'(eval_iir_freq_resp), 32'd0);
    chk_flags("a", 1'b1, 1'b0, 1'b0, 1'b0);
    do_read(16'd3, mk(16'd97, 16'h1003));
    do_read(16'd0, mk(16'd100, 16'h1000));
    do_read(16'd7, mk(16'd93, 16'h1007));
    do_read(16'd8, mk(16'd0, 16'h0000));
    do_read(16'd2000, mk(16'd0, 16'h0000));

    // Write on the same cycle as done is counted
    do_start(16'd4);
    chk("b_ready_drop", 32'(ready), 32'd0);
    for (int k = 0; k < 3; k++) do_valid(XB'(10 + k), PB'(16'h2000 + k), 1'b0);
    do_valid(16'd13, 16'h2003, 1'b1);
    chk_flags("b", 1'b1, 1'b0, 1'b0, 1'b0);
    do_read(16'd3, mk(16'd13, 16'h2003));

    // Overrun: 10 valids into nfft=8
    do_start(16'd8);
    for (int k = 0; k < 10; k++) do_valid(XB'(200 + k), PB'(16'h3000 + k), 1'b0);
    do_done();
    chk_flags("c", 1'b1, 1'b0, 1'b1, 1'b0);
    do_read(16'd0, mk(16'd200, 16'h3000));
    do_read(16'd5, mk(16'd205, 16'h3005));
    do_read(16'd7, mk(16'd207, 16'h3007));
    do_read(16'd8, mk(16'd0, 16'h0000));

    // Short vector: 5 valids into nfft=8
    do_start(16'd8);
    chk("d_ovf_clr", 32'(ovf_err), 32'd0);
    for (int k = 0; k < 5; k++) do_valid(XB'(300 + k), PB'(16'h4000 + k), 1'b0);
    do_done();
    chk_flags("d", 1'b1, 1'b1, 1'b0, 1'b0);
    do_read(16'd4, mk(16'd304, 16'h4004));
    do_read(16'd6, mk(16'd206, 16'h3006));

    // Bad config from READY is rejected and leaves READY intact
    do_start(16'd0);
    chk("e0_eval", 32'(eval_iir_freq_resp), 32'd0);
    chk_flags("e0", 1'b1, 1'b1, 1'b0, 1'b1);
    do_start(16'(DEPTH + 1));
    chk("e1_eval", 32'(eval_iir_freq_resp), 32'd0);
    chk_flags("e1", 1'b1, 1'b1, 1'b0, 1'b1);
    do_read(16'd2, mk(16'd302, 16'h4002));

    // Reset on the 4th valid of a capture
    do_start(16'd8);
    chk("f_cfg_clr", 32'(cfg_err), 32'd0);
    for (int k = 0; k < 3; k++) do_valid(XB'(400 + k), PB'(16'h5000 + k), 1'b0);
    tf_val_valid = 1'b1;
    tf_val_magnitude = 16'd403;
    rst_n = 1'b0;
    tick();
    tf_val_valid = 1'b0;
    chk("f_eval", 32'(eval_iir_freq_resp), 32'd0);
    chk_flags("f", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("f_min_mag", 32'(min_mag), 32'(RST_MIN_MAG));
    rst_n = 1'b1;
    tick();

    // Done and bad start in IDLE
    do_done();
    chk("g_done_idle", 32'(ready), 32'd0);
    do_start(16'd0);
    chk("g_eval", 32'(eval_iir_freq_resp), 32'd0);
    chk("g_cfg", 32'(cfg_err), 32'd1);

    // Normal capture after reset, notch tracking, start ignored mid-capture
    do_start(16'd4);
    chk("h_eval", 32'(eval_iir_freq_resp), 32'd1);
    chk("h_cfg_clr", 32'(cfg_err), 32'd0);
    do_valid(16'd50, 16'h6000, 1'b0);
    do_valid(16'd20, 16'h6001, 1'b0);
    do_start(16'd2);
    chk("h_eval_hold", 32'(eval_iir_freq_resp), 32'd1);
    do_valid(16'd70, 16'h6002, 1'b0);
    do_valid(16'd20, 16'h6003, 1'b0);
    do_done();
    chk_flags("h", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("h_min_mag", 32'(min_mag), 32'(EXP_MIN_MAG));
    chk("h_min_bin", 32'(min_bin), 32'(EXP_MIN_BIN));
    do_read(16'd0, mk(16'd50, 16'h6000));
    do_read(16'd1, mk(16'd20, 16'h6001));
    do_read(16'd2, mk(16'd70, 16'h6002));
    do_read(16'd3, mk(16'd20, 16'h6003));
    chk_flags("h_post_rd", 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iir_resp_buffer.md
IIR_RESP_BUFFER -- requirements
Module: iir_resp_buffer

Interface
REQ-001 Parameter CONFIG_SIZE, default 16: width of the NFFT and bin-index fields.
REQ-002 Parameter XY_BITS, default 16: width of the magnitude field.
REQ-003 Parameter PHASE_BITS, default 16: width of the phase field.
REQ-004 Parameter DEPTH, default 1024: number of buffer entries (bins).
REQ-005 clk  in  1  clock; all logic SHALL be rising-edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 config_nfft  in  CONFIG_SIZE  number of bins to capture.
REQ-008 start  in  1  single-cycle capture request.
REQ-009 eval_iir_freq_resp  out  1  level request to the notch-filter evaluator.
REQ-010 tf_val_magnitude  in  XY_BITS  evaluator magnitude.
REQ-011 tf_val_phase  in  PHASE_BITS  evaluator phase.
REQ-012 tf_val_valid  in  1  magnitude/phase qualifier.
REQ-013 freq_eval_done  in  1  evaluator end-of-vector pulse.
REQ-014 ready  out  1  buffer holds a complete vector.
REQ-015 rd_en, rd_idx  in  1, CONFIG_SIZE  read request and bin index.
REQ-016 rd_valid, rd_mag, rd_phase  out  1, XY_BITS, PHASE_BITS  read response.
REQ-017 short_err, ovf_err, cfg_err  out  1 each  sticky error flags.
REQ-018 min_mag, min_bin  out  XY_BITS, CONFIG_SIZE  notch magnitude and its bin index.

Function
REQ-019 The FSM SHALL have states IDLE, CAPTURE and READY.
REQ-020 A start in IDLE or READY with 1 <= config_nfft <= DEPTH SHALL clear wr_ptr and all error flags, set eval_iir_freq_resp the next cycle, and enter CAPTURE.
REQ-021 A start with config_nfft == 0 or config_nfft > DEPTH SHALL be rejected: set cfg_err and leave the state unchanged.
REQ-022 A start while in CAPTURE SHALL be ignored.
REQ-023 In CAPTURE, tf_val_valid with wr_ptr < config_nfft SHALL write {mag, phase} at address wr_ptr and increment wr_ptr.
REQ-024 tf_val_valid with wr_ptr == config_nfft SHALL discard the data and set ovf_err.
REQ-025 freq_eval_done in CAPTURE SHALL drop eval_iir_freq_resp the next cycle and enter READY.
REQ-026 A write in the same cycle as freq_eval_done SHALL be performed and counted.
REQ-027 On entering READY, a final count != config_nfft SHALL set short_err.
REQ-028 tf_val_valid and freq_eval_done outside CAPTURE SHALL be ignored.
REQ-029 ready SHALL be 1 exactly while in READY.
REQ-030 In READY, rd_en SHALL produce rd_valid=1 one cycle later, with the stored data for rd_idx < config_nfft and zero data otherwise.
REQ-031 rd_en outside READY SHALL give rd_valid=0.
REQ-032 Read-only operation SHALL not alter any state.
REQ-033 A new start from READY SHALL deassert ready the next cycle.

Reset
REQ-034 With rst_n=0 at a clock edge, the FSM SHALL return to IDLE and all outputs SHALL become 0, except min_mag, which SHALL become all-ones.
REQ-035 This SHALL apply mid-capture as well.
REQ-036 Buffer contents SHALL not be cleared by reset.

Configuration
REQ-037 With macro IIR_RESP_MIN_TRACK_EN defined: start SHALL set min_mag to all-ones and min_bin to 0.
REQ-038 With IIR_RESP_MIN_TRACK_EN defined: each accepted write with magnitude strictly less than min_mag SHALL update min_mag and set min_bin to the write address (first occurrence wins).
REQ-039 Without IIR_RESP_MIN_TRACK_EN: min_mag and min_bin SHALL be tied to 0, and no comparator SHALL be synthesised.

Structure
REQ-040 A shared package SHALL hold the FSM state enum, the default widths and DEPTH, and a packed entry typedef {mag, phase}.
REQ-041 Storage SHALL be a sub-module iir_resp_buf_mem: simple dual-port, one write port and one read port, synchronous read with 1-cycle latency, DEPTH x (XY_BITS+PHASE_BITS).

Verification
REQ-042 nfft=8: start, then 8 valids with mag=100-k, then freq_eval_done -> ready=1, no errors, rd_idx=3 returns 97 one cycle later.
REQ-043 nfft=8: 10 valids before done -> ovf_err=1, entries 0..7 intact, short_err=0.
REQ-044 nfft=8: 5 valids, then done -> short_err=1, ready=1.
REQ-045 nfft=0 or nfft=DEPTH+1: start -> cfg_err=1, eval_iir_freq_resp stays 0.
REQ-046 rst_n low at the 4th valid of a capture -> IDLE, eval_iir_freq_resp=0, ready=0; a subsequent start captures normally.
REQ-047 With IIR_RESP_MIN_TRACK_EN: mags {50,20,70,20} -> min_mag=20, min_bin=1; without the macro -> both 0.
